// File: rtl/pulse_pkg.sv
// Shared types, defaults and helpers for the pulse capture controller.
// Enable PULSE_CAPTURE_AUTO_TRIG_EN in the design for the ARMED timeout.
package pulse_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int DEPTH_DEF = 1000;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        ARMED,
        POST,
        DRAIN,
        FLUSH
    } state_t;

    function automatic int cnt_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/pulse_level_trig.sv
// Signed rising level-crossing detector with a one-sample history.
module pulse_level_trig
    import pulse_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             beat,
    input  logic [WIDTH-1:0] sample,
    input  logic [WIDTH-1:0] level,
    output logic             trig
);

    logic [WIDTH-1:0] prev;
    logic             prev_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev    <= '0;
            prev_ok <= 1'b0;
        end else if (clear) begin
            prev_ok <= 1'b0;
        end else if (beat) begin
            prev    <= sample;
            prev_ok <= 1'b1;
        end
    end

    // No crossing can be seen until one ARMED sample has been recorded.
    assign trig = prev_ok
               && ($signed(prev) < $signed(level))
               && ($signed(sample) >= $signed(level));

endmodule

// File: rtl/pulse_capture_ctrl.sv
// Pre/post-trigger pulse capture sequencer around an external stream FIFO.
// Define PULSE_CAPTURE_AUTO_TRIG_EN to add the ARMED-state auto trigger.
module pulse_capture_ctrl
    import pulse_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int CNT_W = cnt_w(DEPTH)
`ifdef PULSE_CAPTURE_AUTO_TRIG_EN
    ,
    parameter int AUTO_TRIG_SAMPLES = 100000
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             arm,
    input  logic             abort,
    input  logic [WIDTH-1:0] trigger_level,
    input  logic [CNT_W-1:0] pre_count,
    input  logic [CNT_W-1:0] post_count,
    input  logic             s_tvalid,
    output logic             s_tready,
    input  logic [WIDTH-1:0] s_tdata,
    output logic             fifo_s_tvalid,
    input  logic             fifo_s_tready,
    output logic [WIDTH-1:0] fifo_s_tdata,
    input  logic             fifo_m_tvalid,
    output logic             fifo_m_tready,
    input  logic [WIDTH-1:0] fifo_m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready,
    output logic [WIDTH-1:0] m_tdata,
    output logic             m_tlast,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic             cfg_error
`ifdef PULSE_CAPTURE_AUTO_TRIG_EN
    ,
    output logic             auto_triggered
`endif
);

    localparam logic [CNT_W:0]   CAP   = (CNT_W+1)'(DEPTH - 1);
    localparam logic [CNT_W:0]   ONE_T = (CNT_W+1)'(1);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] level_q;
    logic [CNT_W-1:0] pre_q;
    logic [CNT_W-1:0] post_q;
    logic [CNT_W-1:0] occ;
    logic [CNT_W-1:0] post_cnt;
    logic [CNT_W-1:0] out_cnt;
    logic [CNT_W:0]   req_sum;
    logic [CNT_W:0]   total;
    logic             cfg_bad;
    logic             arm_ok;
    logic             arm_bad;
    logic             trig_beat;
    logic             clr_trig;
    logic             lvl_trig;
    logic             force_trig;
    logic             trig_hit;
    logic             wr_acc;
    logic             m_beat;

    assign s_tready     = 1'b1;
    assign fifo_s_tdata = s_tdata;
    assign busy         = (state != IDLE);

    assign req_sum = {1'b0, pre_count} + {1'b0, post_count};
    assign total   = {1'b0, pre_q} + {1'b0, post_q};
    assign cfg_bad = (post_count == '0) || (req_sum > CAP);
    assign arm_ok  = (state == IDLE) && arm && !abort && !cfg_bad;
    assign arm_bad = (state == IDLE) && arm && !abort && cfg_bad;

    assign trig_beat = (state == ARMED) && s_tvalid;
    assign trig_hit  = lvl_trig || force_trig;
    assign wr_acc    = fifo_s_tvalid && fifo_s_tready;
    assign m_beat    = m_tvalid && m_tready;
    assign clr_trig  = (state_nx == ARMED) && (state != ARMED);

    pulse_level_trig #(
        .WIDTH (WIDTH)
    ) u_trig (
        .clk    (clk),
        .rst    (reset),
        .clear  (clr_trig),
        .beat   (trig_beat),
        .sample (s_tdata),
        .level  (level_q),
        .trig   (lvl_trig)
    );

`ifdef PULSE_CAPTURE_AUTO_TRIG_EN
    localparam int AT_W = $clog2(AUTO_TRIG_SAMPLES + 1);
    localparam logic [AT_W-1:0] AT_LAST = AT_W'(AUTO_TRIG_SAMPLES - 1);

    logic [AT_W-1:0] at_cnt;
    logic            arm_beat;

    assign arm_beat   = trig_beat && !abort;
    assign force_trig = (at_cnt >= AT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            at_cnt         <= '0;
            auto_triggered <= 1'b0;
        end else begin
            if (clr_trig) begin
                at_cnt <= '0;
            end else if (arm_beat && !force_trig) begin
                at_cnt <= at_cnt + AT_W'(1);
            end
            if (arm_ok) begin
                auto_triggered <= 1'b0;
            end else if (state == ARMED && wr_acc
                         && force_trig && !lvl_trig) begin
                auto_triggered <= 1'b1;
            end
        end
    end
`else
    assign force_trig = 1'b0;
`endif

    always_comb begin
        state_nx      = state;
        fifo_s_tvalid = 1'b0;
        fifo_m_tready = 1'b0;
        m_tvalid      = 1'b0;
        m_tdata       = '0;
        m_tlast       = 1'b0;
        unique case (state)
            IDLE: begin
                if (arm_ok) begin
                    state_nx = (pre_count == '0) ? ARMED : FILL;
                end
            end
            FILL: begin
                fifo_s_tvalid = s_tvalid && !abort;
                if (fifo_s_tvalid && fifo_s_tready && (occ + ONE == pre_q)) begin
                    state_nx = ARMED;
                end
            end
            ARMED: begin
                if (s_tvalid && !abort) begin
                    if (trig_hit) begin
                        fifo_s_tvalid = 1'b1;
                        if (fifo_s_tready) begin
                            state_nx = (post_q == ONE) ? DRAIN : POST;
                        end
                    end else if (pre_q != '0) begin
                        // Rolling window: the oldest entry leaves as the new one lands.
                        fifo_s_tvalid = 1'b1;
                        fifo_m_tready = fifo_s_tready;
                    end
                end
            end
            POST: begin
                fifo_s_tvalid = s_tvalid && !abort;
                if (fifo_s_tvalid && fifo_s_tready && (post_cnt + ONE == post_q)) begin
                    state_nx = DRAIN;
                end
            end
            DRAIN: begin
                m_tvalid      = fifo_m_tvalid;
                m_tdata       = fifo_m_tdata;
                fifo_m_tready = m_tready;
                m_tlast       = ({1'b0, out_cnt} == total - ONE_T);
                if (m_tvalid && m_tready && m_tlast) begin
                    state_nx = IDLE;
                end
            end
            FLUSH: begin
                fifo_m_tready = 1'b1;
                if (!fifo_m_tvalid) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (abort && state != IDLE) begin
            state_nx = FLUSH;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            level_q   <= '0;
            pre_q     <= '0;
            post_q    <= '0;
            occ       <= '0;
            post_cnt  <= '0;
            out_cnt   <= '0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            cfg_error <= 1'b0;
        end else begin
            state     <= state_nx;
            cfg_error <= arm_bad;
            done      <= (state == DRAIN) && m_beat && m_tlast && !abort;
            if (arm_ok) begin
                level_q  <= trigger_level;
                pre_q    <= pre_count;
                post_q   <= post_count;
                occ      <= '0;
                post_cnt <= '0;
                out_cnt  <= '0;
                overflow <= 1'b0;
            end
            if (fifo_s_tvalid && !fifo_s_tready) begin
                overflow <= 1'b1;
            end
            if (state == FILL && wr_acc) begin
                occ <= occ + ONE;
            end
            if (state == ARMED && wr_acc && trig_hit) begin
                post_cnt <= ONE;
            end
            if (state == POST && wr_acc) begin
                post_cnt <= post_cnt + ONE;
            end
            if (state == DRAIN && m_beat) begin
                out_cnt <= out_cnt + ONE;
            end
        end
    end

endmodule
